// File: rtl/video_timing_analyzer.sv
// Recovers beam position, line/frame geometry, active area and NTSC/PAL
// standard from a raw sync/blank stream sampled on the pixel clock enable,
// and runs a lock state machine that qualifies the recovered timing.
module video_timing_analyzer #(
  parameter int LINE_LOCK_CNT = 3,
  parameter int PAL_THRESHOLD = 288
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_ce,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       hblank,
  input  logic       vblank,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic [8:0] line_len,
  output logic [8:0] frame_lines,
  output logic [8:0] active_w,
  output logic [8:0] active_h,
  output logic       frame_start,
  output logic       locked,
  output logic       pal
);

  localparam int              LM_W    = (LINE_LOCK_CNT < 1) ? 1 : $clog2(LINE_LOCK_CNT + 1);
  localparam logic [LM_W-1:0] LM_MAX  = LM_W'(LINE_LOCK_CNT);
  localparam logic [8:0]      CNT_MAX = 9'd511;
  localparam logic [9:0]      PAL_THR = 10'(PAL_THRESHOLD);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LINE_OK = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Increment that sticks at the 9-bit ceiling instead of wrapping.
  function automatic logic [8:0] sat_inc(input logic [8:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 9'd1;
  endfunction

  logic            hs_prev_q, hs_prev_d;
  logic            vs_prev_q, vs_prev_d;
  logic            vpend_q, vpend_d;
  logic [8:0]      x_q, x_d;
  logic [8:0]      y_q, y_d;
  logic [8:0]      hact_q, hact_d;
  logic [8:0]      vact_q, vact_d;
  logic [8:0]      line_len_q, line_len_d;
  logic [8:0]      frame_lines_q, frame_lines_d;
  logic [8:0]      active_w_q, active_w_d;
  logic [8:0]      active_h_q, active_h_d;
  logic [LM_W-1:0] line_match_q, line_match_d;
  logic            frame_start_q, frame_start_d;
  logic            pal_q, pal_d;
  state_t          state_q, state_d;

  logic hrise, vrise, frame_end, line_good, frame_ok;

  // Edge events are only meaningful on pixel-enable cycles.
  assign hrise     = pix_ce & hsync & ~hs_prev_q;
  assign vrise     = pix_ce & vsync & ~vs_prev_q;
  assign frame_end = hrise & (vpend_q | vrise);
  // The line just ended matches the previous one (a zero length means no history yet).
  assign line_good = (sat_inc(x_q) == line_len_q) && (line_len_q != 9'd0);
  assign frame_ok  = (sat_inc(y_q) == frame_lines_q) && (frame_lines_q != 9'd0);

  // Position counters, geometry capture and match counting for the next pixel.
  always_comb begin
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    vpend_d       = vpend_q;
    x_d           = x_q;
    y_d           = y_q;
    hact_d        = hact_q;
    vact_d        = vact_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    active_w_d    = active_w_q;
    active_h_d    = active_h_q;
    line_match_d  = line_match_q;
    frame_start_d = 1'b0;
    if (pix_ce) begin
      hs_prev_d = hsync;
      vs_prev_d = vsync;
      // A vsync edge mid-line waits here until the next line start.
      vpend_d   = hrise ? 1'b0 : (vrise ? 1'b1 : vpend_q);
      if (hrise) begin
        line_len_d   = sat_inc(x_q);
        active_w_d   = hblank ? hact_q : sat_inc(hact_q);
        x_d          = 9'd0;
        hact_d       = 9'd0;
        line_match_d = line_good ? ((line_match_q >= LM_MAX) ? LM_MAX : line_match_q + 1'b1)
                                 : '0;
      end else begin
        x_d = sat_inc(x_q);
        if (!hblank) hact_d = sat_inc(hact_q);
      end
      if (frame_end) begin
        frame_lines_d = sat_inc(y_q);
        active_h_d    = vact_q;
        y_d           = 9'd0;
        vact_d        = 9'd0;
        frame_start_d = 1'b1;
      end else if (hrise) begin
        y_d = sat_inc(y_q);
        if (!vblank) vact_d = sat_inc(vact_q);
      end
    end
  end

  // Lock state machine: stable lines first, then two agreeing frame ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: begin
        if (hrise && (line_match_d == LM_MAX)) state_d = LINE_OK;
      end
      LINE_OK: begin
        if (hrise && (line_match_d == '0))  state_d = SEARCH;
        else if (frame_end && frame_ok)      state_d = LOCKED;
      end
      LOCKED: begin
        if ((hrise && !line_good) || (frame_end && !frame_ok) ||
            (pix_ce && ((x_q == CNT_MAX) || (y_q == CNT_MAX))))
          state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  // PAL flag tracks the lock so it can never be set while unlocked.
  assign pal_d = (state_d == LOCKED) && ({1'b0, frame_lines_d} >= PAL_THR);

  // State registers; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      vpend_q       <= 1'b0;
      x_q           <= 9'd0;
      y_q           <= 9'd0;
      hact_q        <= 9'd0;
      vact_q        <= 9'd0;
      line_len_q    <= 9'd0;
      frame_lines_q <= 9'd0;
      active_w_q    <= 9'd0;
      active_h_q    <= 9'd0;
      line_match_q  <= '0;
      frame_start_q <= 1'b0;
      pal_q         <= 1'b0;
      state_q       <= SEARCH;
    end else begin
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      vpend_q       <= vpend_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hact_q        <= hact_d;
      vact_q        <= vact_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      active_w_q    <= active_w_d;
      active_h_q    <= active_h_d;
      line_match_q  <= line_match_d;
      frame_start_q <= frame_start_d;
      pal_q         <= pal_d;
      state_q       <= state_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign active_w    = active_w_q;
  assign active_h    = active_h_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == LOCKED);
  assign pal         = pal_q;

endmodule

// File: tb/tb_video_timing_analyzer.sv
// Directed bench for video_timing_analyzer: a raw sync/blank generator, a
// behavioural reference checked every cycle, and hand-computed spot checks.
module tb_video_timing_analyzer;

  localparam int LLC  = 3;
  localparam int PALT = 288;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_ce = 1'b0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic       hblank = 1'b0;
  logic       vblank = 1'b0;
  logic [8:0] x, y, line_len, frame_lines, active_w, active_h;
  logic       frame_start, locked, pal;

  video_timing_analyzer #(.LINE_LOCK_CNT(LLC), .PAL_THRESHOLD(PALT)) dut (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .x(x), .y(y), .line_len(line_len), .frame_lines(frame_lines),
    .active_w(active_w), .active_h(active_h),
    .frame_start(frame_start), .locked(locked), .pal(pal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Beam position and geometry as plain integers; lock progress as a
  // level 0 (searching), 1 (lines stable), 2 (locked).
  int m_x, m_y, m_len, m_fl, m_aw, m_ah, m_hact, m_vact, m_match, m_lvl;
  bit m_hsp, m_vsp, m_vpend, m_fs, m_pal;
  bit e_hr, e_vr, e_fend, e_good, e_fok;

  function automatic int sat9(input int v);
    return (v > 511) ? 511 : v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_x = 0; m_y = 0; m_len = 0; m_fl = 0; m_aw = 0; m_ah = 0;
        m_hact = 0; m_vact = 0; m_match = 0; m_lvl = 0;
        m_hsp = 0; m_vsp = 0; m_vpend = 0; m_fs = 0; m_pal = 0;
      end else begin
        m_fs = 0;
        if (pix_ce) begin
          e_hr   = hsync && !m_hsp;
          e_vr   = vsync && !m_vsp;
          e_fend = e_hr && (m_vpend || e_vr);
          e_good = (sat9(m_x + 1) == m_len) && (m_len != 0);
          e_fok  = (sat9(m_y + 1) == m_fl) && (m_fl != 0);
          if (e_hr) m_match = e_good ? ((m_match < LLC) ? m_match + 1 : LLC) : 0;
          if (m_lvl == 0) begin
            if (e_hr && m_match == LLC) m_lvl = 1;
          end else if (m_lvl == 1) begin
            if (e_hr && m_match == 0) m_lvl = 0;
            else if (e_fend && e_fok) m_lvl = 2;
          end else begin
            if ((e_hr && !e_good) || (e_fend && !e_fok) || m_x == 511 || m_y == 511) m_lvl = 0;
          end
          m_hsp = hsync;
          m_vsp = vsync;
          if (e_hr) m_vpend = 0;
          else if (e_vr) m_vpend = 1;
          if (e_hr) begin
            m_len  = sat9(m_x + 1);
            m_aw   = sat9(m_hact + (hblank ? 0 : 1));
            m_x    = 0;
            m_hact = 0;
          end else begin
            m_x = sat9(m_x + 1);
            if (!hblank) m_hact = sat9(m_hact + 1);
          end
          if (e_fend) begin
            m_fl = sat9(m_y + 1); m_ah = m_vact; m_y = 0; m_vact = 0; m_fs = 1;
          end else if (e_hr) begin
            m_y = sat9(m_y + 1);
            if (!vblank) m_vact = sat9(m_vact + 1);
          end
        end
        m_pal = (m_lvl == 2) && (m_fl >= PALT);
      end
    end
  end

  // Every-cycle comparison against the model (stops printing after a flood).
  initial begin
    forever begin
      @(negedge clk);
      if (n_fail < 40) begin
        chk("cyc_x", int'(x), m_x);
        chk("cyc_y", int'(y), m_y);
        chk("cyc_line_len", int'(line_len), m_len);
        chk("cyc_frame_lines", int'(frame_lines), m_fl);
        chk("cyc_active_w", int'(active_w), m_aw);
        chk("cyc_active_h", int'(active_h), m_ah);
        chk("cyc_frame_start", int'(frame_start), int'(m_fs));
        chk("cyc_locked", int'(locked), (m_lvl == 2) ? 1 : 0);
        chk("cyc_pal", int'(pal), int'(m_pal));
      end
    end
  end

  // ---------------- stimulus ----------------
  int g_px, g_hs, g_hblo, g_hbhi, g_nl, g_vs, g_vblo, g_vbhi;
  int cur_line, cur_px, gap_cnt;
  bit gap_en, hs_kill;

  task automatic step();
    if (gap_en) begin
      gap_cnt++;
      if (gap_cnt == 4) begin
        gap_cnt = 0;
        pix_ce  = 1'b0;
        @(posedge clk); #1;
      end
    end
    pix_ce = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      hsync  = !hs_kill && (cur_px < g_hs);
      vsync  = (cur_line < g_vs);
      hblank = (cur_px >= g_hbhi) || (cur_px < g_hblo);
      vblank = (cur_line >= g_vbhi) || (cur_line < g_vblo);
      step();
      cur_px++;
      if (cur_px >= g_px) begin
        cur_px   = 0;
        cur_line = (cur_line + 1) % g_nl;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_line_len"}, int'(line_len), 0);
    chk({tag, "_frame_lines"}, int'(frame_lines), 0);
    chk({tag, "_active_w"}, int'(active_w), 0);
    chk({tag, "_active_h"}, int'(active_h), 0);
    chk({tag, "_flags"}, int'({frame_start, locked, pal}), 0);
  endtask

  task automatic do_reset();
    pix_ce  = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n  = 1'b1;
    cur_line = 0;
    cur_px   = 0;
    gap_cnt  = 0;
  endtask

  // Scaled NTSC: 12-pixel lines keep frames short; vertical timing is real.
  task automatic set_ntsc_small();
    g_px = 12; g_hs = 2; g_hblo = 2; g_hbhi = 10;
    g_nl = 263; g_vs = 3; g_vblo = 16; g_vbhi = 258;
  endtask

  initial begin
    hs_kill = 0;
    gap_en  = 0;
    // Real NTSC horizontal geometry.
    g_px = 454; g_hs = 34; g_hblo = 68; g_hbhi = 440;
    g_nl = 263; g_vs = 3; g_vblo = 16; g_vbhi = 258;
    do_reset();
    cur_line = 5;
    run_pixels(3 * 454);
    chk("ntsc_line_len", int'(line_len), 454);
    chk("ntsc_active_w", int'(active_w), 372);
    g_hblo = 93; g_hbhi = 413;
    run_pixels(2 * 454);
    chk("border_active_w", int'(active_w), 320);
    chk("border_line_len", int'(line_len), 454);

    // Vertical NTSC lock from reset.
    set_ntsc_small();
    do_reset();
    run_pixels(1);
    chk("first_frame_start", int'(frame_start), 1);
    chk("first_frame_lines", int'(frame_lines), 1);
    chk("first_line_len", int'(line_len), 1);
    run_pixels(526 * 12 - 1);
    chk("ntsc_not_locked_yet", int'(locked), 0);
    run_pixels(1);
    chk("ntsc_locked", int'(locked), 1);
    chk("ntsc_frame_lines", int'(frame_lines), 263);
    chk("ntsc_active_h", int'(active_h), 242);
    chk("ntsc_small_line_len", int'(line_len), 12);
    chk("ntsc_small_active_w", int'(active_w), 8);
    chk("ntsc_pal", int'(pal), 0);
    run_pixels(11);

    // Hidden border keeps lock.
    g_hblo = 3; g_hbhi = 9;
    run_pixels(3 * 12);
    chk("small_border_active_w", int'(active_w), 6);
    chk("small_border_locked", int'(locked), 1);
    g_hblo = 2; g_hbhi = 10;
    run_pixels(12);

    // One short line while locked.
    g_px = 11;
    run_pixels(11);
    g_px = 12;
    run_pixels(1);
    chk("short_line_unlock", int'(locked), 0);
    chk("short_line_len", int'(line_len), 11);
    run_pixels(11);
    run_pixels((g_nl - cur_line) * 12);
    chk("short_line_wait_frame", int'(locked), 0);
    run_pixels(1);
    chk("short_line_relock", int'(locked), 1);
    run_pixels(11);

    // Hsync removed while locked.
    hs_kill = 1;
    run_pixels(600);
    chk("nohs_x_sat", int'(x), 511);
    chk("nohs_unlock", int'(locked), 0);
    hs_kill = 0;
    for (int i = 0; i < 1100 && !locked; i++) run_pixels(12);
    chk("nohs_relock", int'(locked), 1);
    chk("nohs_relock_frame_lines", int'(frame_lines), 263);

    // PAL.
    set_ntsc_small();
    g_nl = 313; g_vbhi = 308;
    do_reset();
    run_pixels(626 * 12);
    chk("pal_not_locked_yet", int'(locked), 0);
    chk("pal_flag_unlocked", int'(pal), 0);
    run_pixels(1);
    chk("pal_locked", int'(locked), 1);
    chk("pal_flag", int'(pal), 1);
    chk("pal_frame_lines", int'(frame_lines), 313);
    chk("pal_active_h", int'(active_h), 292);

    // Gapped pixel enable, then async reset mid-line.
    set_ntsc_small();
    do_reset();
    gap_en = 1;
    run_pixels(526 * 12);
    chk("gap_not_locked_yet", int'(locked), 0);
    run_pixels(1);
    chk("gap_locked", int'(locked), 1);
    chk("gap_frame_lines", int'(frame_lines), 263);
    chk("gap_active_h", int'(active_h), 242);
    chk("gap_active_w", int'(active_w), 8);
    run_pixels(5);
    reset_n = 1'b0;
    #2;
    chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    gap_en  = 0;
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: always terminate with a summary.
  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
